// File: rtl/jam_cost_server.sv
// jam_cost_server: loads the 8x8 cost table for the assignment engine, serves lookups while it runs,
// and hands its result downstream before re-arming for the next table.
module jam_cost_server #(
    parameter int DATA_W = 7,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              jam_rst,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [DATA_W-1:0] Cost,
    input  logic              jam_valid,
    input  logic [9:0]        jam_min_cost,
    input  logic [3:0]        jam_match_count,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [9:0]        res_cost,
    output logic [3:0]        res_count,
    output logic [CNT_W-1:0]  res_cycles,
    output logic [12:0]       load_sum
);
    typedef enum logic [1:0] {LOAD, RUN, REPORT} state_t;
    state_t            state_q, state_d;
    logic [5:0]        addr_q, addr_d;
    logic              jam_rst_q, jam_rst_d;
    logic              res_valid_q, res_valid_d;
    logic [9:0]        res_cost_q, res_cost_d;
    logic [3:0]        res_count_q, res_count_d;
    logic [CNT_W-1:0]  res_cycles_q, res_cycles_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [12:0]       load_sum_q, load_sum_d;
    logic [DATA_W-1:0] mem [64];
    logic              accept, capture, res_fire;

    assign accept   = in_valid && state_q == LOAD;
    assign capture  = jam_valid && state_q == RUN;
    assign res_fire = res_valid_q && res_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= LOAD;
            addr_q       <= '0;
            jam_rst_q    <= 1'b1;
            res_valid_q  <= 1'b0;
            res_cost_q   <= '0;
            res_count_q  <= '0;
            res_cycles_q <= '0;
            cnt_q        <= '0;
            load_sum_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            jam_rst_q    <= jam_rst_d;
            res_valid_q  <= res_valid_d;
            res_cost_q   <= res_cost_d;
            res_count_q  <= res_count_d;
            res_cycles_q <= res_cycles_d;
            cnt_q        <= cnt_d;
            load_sum_q   <= load_sum_d;
        end
    end

    // Table storage is deliberately not reset; RUN is only reachable after a full 64-beat load.
    always_ff @(posedge CLK) begin
        if (accept) mem[addr_q] <= in_data;
    end

    always_comb begin
        state_d = (accept && addr_q == 6'd63) ? RUN :
                  capture                     ? REPORT :
                  res_fire                    ? LOAD : state_q;
    end

    always_comb begin
        addr_d       = accept ? addr_q + 6'd1 : res_fire ? 6'd0 : addr_q;
        load_sum_d   = accept ? load_sum_q + 13'(in_data) : res_fire ? 13'd0 : load_sum_q;
        cnt_d        = state_q == LOAD ? '0 :
                       (state_q == RUN && !jam_valid && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        res_valid_d  = capture ? 1'b1 : res_fire ? 1'b0 : res_valid_q;
        res_cost_d   = capture ? jam_min_cost : res_cost_q;
        res_count_d  = capture ? jam_match_count : res_count_q;
        res_cycles_d = capture ? cnt_q : res_cycles_q;
        jam_rst_d    = state_d == LOAD;
    end

    always_comb begin
        in_ready = state_q == LOAD;
        Cost     = state_q == RUN ? mem[{W, J}] : '0;
    end

    assign jam_rst    = jam_rst_q;
    assign res_valid  = res_valid_q;
    assign res_cost   = res_cost_q;
    assign res_count  = res_count_q;
    assign res_cycles = res_cycles_q;
    assign load_sum   = load_sum_q;
endmodule

// File: tb/tb_jam_cost_server.sv
// tb_jam_cost_server: directed and randomized checks of jam_cost_server against a transaction-level model.
module tb_jam_cost_server;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic [6:0]  in_data = '0;
    logic        in_ready, jam_rst, res_valid;
    logic [2:0]  W = '0, J = '0;
    logic [6:0]  Cost;
    logic        jam_valid = 1'b0;
    logic [9:0]  jam_min_cost = '0;
    logic [3:0]  jam_match_count = '0;
    logic        res_ready = 1'b0;
    logic [9:0]  res_cost;
    logic [3:0]  res_count;
    logic [15:0] res_cycles;
    logic [12:0] load_sum;

    int checks = 0, failures = 0;

    // model: phase 0=load 1=run 2=report
    int         ph;
    logic [6:0] beats[$];
    logic [6:0] tbl[64];
    int         cyc;
    logic       rv;
    logic [9:0] rc;
    logic [3:0] rk;
    logic [15:0] rcy;

    jam_cost_server dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .jam_rst(jam_rst), .W(W), .J(J), .Cost(Cost), .jam_valid(jam_valid),
        .jam_min_cost(jam_min_cost), .jam_match_count(jam_match_count), .res_valid(res_valid),
        .res_ready(res_ready), .res_cost(res_cost), .res_count(res_count),
        .res_cycles(res_cycles), .load_sum(load_sum)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int msum();
        int s = 0;
        foreach (beats[i]) s += int'(beats[i]);
        return s;
    endfunction

    function automatic logic [6:0] mcost(input logic [2:0] w, input logic [2:0] j);
        return ph == 1 ? tbl[{w, j}] : 7'd0;
    endfunction

    task automatic check_regs();
        check("in_ready", 32'(in_ready), 32'(ph == 0));
        check("jam_rst", 32'(jam_rst), 32'(ph == 0));
        check("res_valid", 32'(res_valid), 32'(rv));
        check("res_cost", 32'(res_cost), 32'(rc));
        check("res_count", 32'(res_count), 32'(rk));
        check("res_cycles", 32'(res_cycles), 32'(rcy));
        check("load_sum", 32'(load_sum), 32'(msum()));
    endtask

    task automatic model_reset();
        ph = 0; beats.delete(); rv = 1'b0; rc = '0; rk = '0; rcy = '0; cyc = 0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        model_reset();
        check_regs();
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic probe(input logic [2:0] w, input logic [2:0] j);
        W = w; J = j;
        #1;
        check("cost", 32'(Cost), 32'(mcost(w, j)));
    endtask

    task automatic tick(input logic iv, input logic [6:0] d, input logic jv,
                        input logic [9:0] mc, input logic [3:0] mk, input logic rr);
        in_valid = iv; in_data = d; jam_valid = jv;
        jam_min_cost = mc; jam_match_count = mk; res_ready = rr;
        probe(3'($urandom), 3'($urandom));
        @(posedge CLK); #1;
        case (ph)
            0: if (iv) begin
                beats.push_back(d);
                if (beats.size() == 64) begin
                    ph = 1; cyc = 0;
                    foreach (tbl[i]) tbl[i] = beats[i];
                end
            end
            1: if (jv) begin
                rc = mc; rk = mk; rcy = 16'(cyc); rv = 1'b1; ph = 2;
            end else if (cyc < 65535) cyc++;
            default: if (rr) begin
                rv = 1'b0; ph = 0; beats.delete();
            end
        endcase
        check_regs();
    endtask

    task automatic rand_round();
        int g = 0;
        while (ph == 0 && g < 400) begin
            tick($urandom_range(0, 3) != 0, 7'($urandom), 1'($urandom), 10'($urandom), 4'($urandom), 1'($urandom));
            g++;
            if (g == 30 && $urandom_range(0, 3) == 0) do_reset();
        end
        repeat ($urandom_range(0, 40)) tick(1'($urandom), 7'($urandom), 1'b0, 10'($urandom), 4'($urandom), 1'($urandom));
        tick(1'($urandom), 7'($urandom), 1'b1, 10'($urandom), 4'($urandom), 1'b0);
        g = 0;
        while (ph == 2 && g < 200) begin
            tick(1'($urandom), 7'($urandom), 1'b1, 10'($urandom), 4'($urandom), $urandom_range(0, 2) == 0);
            g++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_regs();
        probe(3'd3, 3'd5);
        RST = 1'b0;

        for (int c = 0, n = 0; n < 64; c++) begin
            if (c % 3 == 2) tick(1'b0, 7'd0, 1'b0, 10'd0, 4'd0, 1'b0);
            else begin tick(1'b1, 7'(n), 1'b0, 10'd0, 4'd0, 1'b0); n++; end
        end
        check("run_in_ready", 32'(in_ready), 32'd0);
        check("run_jam_rst", 32'(jam_rst), 32'd0);
        check("sum_2016", 32'(load_sum), 32'd2016);
        W = 3'd3; J = 3'd5; #1; check("cost_35", 32'(Cost), 32'd29);
        W = 3'd7; J = 3'd7; #1; check("cost_77", 32'(Cost), 32'd63);

        repeat (100) tick(1'b1, 7'd127, 1'b0, 10'd0, 4'd0, 1'b0);
        W = 3'd0; J = 3'd0; #1; check("cost_00_after_junk", 32'(Cost), 32'd0);
        tick(1'b0, 7'd0, 1'b1, 10'd300, 4'd2, 1'b0);
        check("res_valid_up", 32'(res_valid), 32'd1);
        check("res_cost_300", 32'(res_cost), 32'd300);
        check("res_count_2", 32'(res_count), 32'd2);
        check("res_cycles_100", 32'(res_cycles), 32'd100);
        for (int i = 0; i < 10; i++) tick(1'b1, 7'd5, 1'b1, 10'(i + 7), 4'(i), 1'b0);
        check("res_cost_hold", 32'(res_cost), 32'd300);
        check("res_cycles_hold", 32'(res_cycles), 32'd100);

        tick(1'b0, 7'd0, 1'b1, 10'd1, 4'd1, 1'b1);
        check("ack_res_valid", 32'(res_valid), 32'd0);
        check("ack_jam_rst", 32'(jam_rst), 32'd1);
        check("ack_in_ready", 32'(in_ready), 32'd1);
        check("ack_sum", 32'(load_sum), 32'd0);
        repeat (64) tick(1'b1, 7'd10, 1'b0, 10'd0, 4'd0, 1'b0);
        check("sum_640", 32'(load_sum), 32'd640);
        W = 3'd6; J = 3'd1; #1; check("cost_10", 32'(Cost), 32'd10);
        tick(1'b0, 7'd0, 1'b1, 10'd9, 4'd9, 1'b1);
        tick(1'b0, 7'd0, 1'b1, 10'd9, 4'd9, 1'b1);

        repeat (20) tick(1'b1, 7'($urandom), 1'b0, 10'd0, 4'd0, 1'b0);
        do_reset();
        repeat (63) tick(1'b1, 7'($urandom), 1'b1, 10'd0, 4'd0, 1'b0);
        check("jam_rst_63", 32'(jam_rst), 32'd1);
        tick(1'b1, 7'($urandom), 1'b0, 10'd0, 4'd0, 1'b0);
        check("jam_rst_64", 32'(jam_rst), 32'd0);
        tick(1'b0, 7'd0, 1'b1, 10'd44, 4'd3, 1'b1);
        tick(1'b0, 7'd0, 1'b1, 10'd0, 4'd0, 1'b1);

        for (int r = 0; r < 8; r++) rand_round();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jam_cost_server.md
Name: jam_cost_server

Overview:
- Feeds the job-assignment engine: loads the 8x8 worker/job cost table from a valid/ready byte stream.
- Holds the engine in reset until the table is complete, then serves its combinational cost lookups (W,J -> Cost).
- When the engine raises Valid, captures its result plus a run-cycle count and hands it downstream over a valid/ready port, then re-arms for the next table.

Parameters:
DATA_W, 7, cost entry width (matches engine Cost port)
CNT_W, 16, run-cycle counter width (saturating)

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
in_valid  in  1  cost stream beat valid
in_data  in  DATA_W  cost entry; beat n is entry {w,j}=n (worker-major)
in_ready  out  1  table accepting beats
jam_rst  out  1  registered reset to engine, active-high
W  in  3  engine worker index
J  in  3  engine job index
Cost  out  DATA_W  table[{W,J}]
jam_valid  in  1  engine Valid
jam_min_cost  in  10  engine MinCost
jam_match_count  in  4  engine MatchCount
res_valid  out  1  result held
res_ready  in  1  downstream accepts result
res_cost  out  10  captured MinCost
res_count  out  4  captured MatchCount
res_cycles  out  CNT_W  RUN cycles before jam_valid
load_sum  out  13  sum of 64 loaded entries (max 8128)

Behaviour:
- FSM states: LOAD, RUN, REPORT. Reset state is LOAD.
- Reset values: addr=0, in_ready=1, jam_rst=1, res_valid=0, res_*=0, load_sum=0.
- Table storage (64 x DATA_W) is not reset. Cost is forced to 0 whenever state != RUN.

LOAD:
- in_ready=1 (combinational from state).
- Each in_valid&in_ready edge: table[addr]<=in_data, addr<=addr+1 (6-bit), load_sum<=load_sum+in_data.
- Beat accepted with addr==63: go to RUN next edge; addr wraps to 0; jam_rst goes 0 on that same edge (registered, glitch-free).
- Gaps in in_valid are allowed and only stall the load.
- jam_valid is ignored.

RUN:
- in_ready=0; in_valid is ignored and nothing is written.
- Cost=table[{W,J}] combinational, zero latency. The engine samples it in the same cycle.
- Cycle counter: cleared on entry, +1 per RUN cycle with jam_valid=0, saturates at 2^CNT_W-1.
- jam_valid=1 (first cycle seen): on that edge capture res_cost<=jam_min_cost, res_count<=jam_match_count, res_cycles<=counter; res_valid<=1; go to REPORT.
- jam_valid is sticky in the engine; only the first cycle is used.

REPORT:
- res_* are stable while res_valid=1 and res_ready=0. jam_rst stays 0 and Cost stays 0.
- res_valid&res_ready edge: res_valid<=0, jam_rst<=1, load_sum<=0, addr<=0, go to LOAD.
- in_ready rises in the cycle after the handshake. res_* data keeps its last values.

Other rules:
- load_sum is valid from RUN entry until cleared at the next LOAD entry.
- No new table can overwrite a result that has not been acknowledged.
- RST mid-operation (any state) returns to LOAD immediately: jam_rst=1, res_valid=0. A partially loaded table must be reloaded in full (64 beats) before jam_rst falls.

Test Plan:
1. Assert RST for 2 cycles, release -> in_ready=1, jam_rst=1, res_valid=0, Cost=0 for any W/J, load_sum=0.
2. Stream entry n=8w+j with in_valid low every 3rd cycle -> exactly 64 beats accepted. Cycle after 64th: in_ready=0, jam_rst=0, load_sum=2016. Drive W=3,J=5 -> Cost=29; W=7,J=7 -> Cost=63.
3. Hold jam_valid=0 for 100 RUN cycles, then jam_valid=1, min_cost=300, match_count=2 -> next cycle res_valid=1, res_cost=300, res_count=2, res_cycles=100. Hold res_ready=0 for 10 cycles (jam_valid kept 1) -> outputs unchanged.
4. From test 3, pulse res_ready=1 -> next cycle res_valid=0, jam_rst=1, in_ready=1, load_sum=0. Load all entries =10 -> load_sum=640, Cost=10 at any W/J.
5. Assert RST after 20 accepted beats -> in_ready stays 1 and jam_rst stays 1. After release, 63 beats keep jam_rst=1; the 64th beat makes jam_rst=0 the next cycle.
6. During RUN drive in_valid=1 with in_data=127 -> table unchanged (Cost at W=0,J=0 still 0 from test 2). During LOAD pulse jam_valid=1 -> res_valid stays 0 and state stays LOAD.
